// File: rtl/dispatch_pkg.sv
// Shared types and defaults for the job dispatcher.
// Optional feature macro: JOB_DISPATCHER_BITMAP_EN (see job_dispatcher.sv).
package dispatch_pkg;

  localparam int unsigned NUM_CORES_DEF = 16;
  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned MEM_DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } dispatch_state_t;

  // Index width for a vector of n entries; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible core at or above rr_ptr, wrapping.
module rr_arbiter
  import dispatch_pkg::*;
#(
  parameter int unsigned NUM_CORES = NUM_CORES_DEF,
  localparam int unsigned IDX_W    = idx_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] eligible,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic [NUM_CORES-1:0] gnt_c,
  output logic [IDX_W-1:0]     idx_c,
  output logic                 any_c
);

  logic [IDX_W-1:0] cand;

  // Walk the cores in rotated order and keep the first eligible one.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NUM_CORES);
      if (!any_c && eligible[cand]) begin
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
        any_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/job_dispatcher.sv
// Hands out data-memory addresses to worker cores and counts prime results.
// Define JOB_DISPATCHER_BITMAP_EN to add the per-address prime_map output.
module job_dispatcher
  import dispatch_pkg::*;
#(
  parameter int unsigned NUM_CORES = NUM_CORES_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic [NUM_CORES-1:0] core_req,
  output logic [NUM_CORES-1:0] core_gnt,
  output logic [ADDR_W-1:0]    core_addr,
  input  logic [NUM_CORES-1:0] core_res_valid,
  input  logic [NUM_CORES-1:0] core_res,
  output logic [ADDR_W:0]      prime_count
`ifdef JOB_DISPATCHER_BITMAP_EN
  ,
  output logic [MEM_DEPTH-1:0] prime_map
`endif
);

  localparam int unsigned IDX_W = idx_width(NUM_CORES);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned NXT_W = ADDR_W + 1;

  dispatch_state_t      state_q, state_d;
  logic [NXT_W-1:0]     next_addr_q, next_addr_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0] core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0] core_gnt_q, core_gnt_d;
  logic [ADDR_W-1:0]    core_addr_q, core_addr_d;
  logic [CNT_W-1:0]     prime_count_q, prime_count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [NUM_CORES-1:0] eligible_c;
  logic [NUM_CORES-1:0] arb_gnt_c;
  logic [IDX_W-1:0]     arb_idx_c;
  logic                 arb_any_c;
  logic [NUM_CORES-1:0] counted_c;
  logic [CNT_W-1:0]     count_inc_c;

  assign eligible_c = core_req & ~core_busy_q;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_arb (
    .eligible (eligible_c),
    .rr_ptr   (rr_ptr_q),
    .gnt_c    (arb_gnt_c),
    .idx_c    (arb_idx_c),
    .any_c    (arb_any_c)
  );

  // Results only count from cores that actually hold a job.
  always_comb begin
    counted_c   = core_res_valid & core_res & core_busy_q;
    count_inc_c = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      count_inc_c = count_inc_c + CNT_W'(counted_c[i]);
    end
  end

  // Run control, dispatch and result accounting.
  always_comb begin
    state_d       = state_q;
    next_addr_d   = next_addr_q;
    rr_ptr_d      = rr_ptr_q;
    core_gnt_d    = '0;
    core_addr_d   = core_addr_q;
    prime_count_d = prime_count_q + count_inc_c;

    case (state_q)
      IDLE: begin
        if (start) begin
          next_addr_d   = '0;
          rr_ptr_d      = '0;
          prime_count_d = count_inc_c;
          state_d       = DISPATCH;
        end
      end
      DISPATCH: begin
        if (arb_any_c) begin
          core_gnt_d  = arb_gnt_c;
          core_addr_d = ADDR_W'(next_addr_q);
          next_addr_d = next_addr_q + NXT_W'(1);
          rr_ptr_d    = IDX_W'((32'(arb_idx_c) + 32'd1) % NUM_CORES);
          if (next_addr_q == NXT_W'(MEM_DEPTH - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (core_busy_q == '0 && core_gnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    core_busy_d = (core_busy_q & ~core_res_valid) | core_gnt_d;
    busy_d      = (state_d == DISPATCH) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      next_addr_q   <= '0;
      rr_ptr_q      <= '0;
      core_busy_q   <= '0;
      core_gnt_q    <= '0;
      core_addr_q   <= '0;
      prime_count_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_addr_q   <= next_addr_d;
      rr_ptr_q      <= rr_ptr_d;
      core_busy_q   <= core_busy_d;
      core_gnt_q    <= core_gnt_d;
      core_addr_q   <= core_addr_d;
      prime_count_q <= prime_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign core_gnt    = core_gnt_q;
  assign core_addr   = core_addr_q;
  assign prime_count = prime_count_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef JOB_DISPATCHER_BITMAP_EN
  logic [ADDR_W-1:0]    job_addr_q [NUM_CORES];
  logic [ADDR_W-1:0]    job_addr_d [NUM_CORES];
  logic [MEM_DEPTH-1:0] prime_map_q, prime_map_d;

  // Remember each core's job address and mark primes at that address.
  always_comb begin
    job_addr_d = job_addr_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_gnt_d[i]) begin
        job_addr_d[i] = core_addr_d;
      end
    end
    prime_map_d = (state_q == IDLE && start) ? '0 : prime_map_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (counted_c[i]) begin
        prime_map_d[job_addr_q[i]] = 1'b1;
      end
    end
  end

  // Bitmap registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        job_addr_q[i] <= '0;
      end
      prime_map_q <= '0;
    end else begin
      job_addr_q  <= job_addr_d;
      prime_map_q <= prime_map_d;
    end
  end

  assign prime_map = prime_map_q;
`endif

endmodule

// File: tb/tb_job_dispatcher.sv
// Randomized self-checking bench for job_dispatcher with a behavioural model.
module tb_job_dispatcher;

  localparam int unsigned N     = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;
  localparam int P_IDLE = 0, P_DISP = 1, P_DRAIN = 2, P_DONE = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [N-1:0]  core_req = '0;
  logic [N-1:0]  core_gnt;
  logic [AW-1:0] core_addr;
  logic [N-1:0]  core_res_valid = '0;
  logic [N-1:0]  core_res = '0;
  logic [AW:0]   prime_count;
`ifdef JOB_DISPATCHER_BITMAP_EN
  logic [DEPTH-1:0] prime_map;
`endif

  job_dispatcher dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .core_req       (core_req),
    .core_gnt       (core_gnt),
    .core_addr      (core_addr),
    .core_res_valid (core_res_valid),
    .core_res       (core_res),
    .prime_count    (prime_count)
`ifdef JOB_DISPATCHER_BITMAP_EN
    ,
    .prime_map      (prime_map)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- core environment ----------------
  typedef struct packed {
    logic [3:0]    core;
    logic [AW-1:0] addr;
  } gnt_rec_t;

  gnt_rec_t      glog[$];
  int            done_cnt = 0;
  logic [N-1:0]  req_mask = '0;
  bit            hold_res = 1'b0;
  bit            stray_en = 1'b0;
  int            res_mode = 0;   // 0: res=0, 1: res=~addr[0], 2: random
  int            lat_fixed = 0;  // 0 means random 1..5
  bit            e_busy[N];
  int            e_cnt[N];
  logic [AW-1:0] e_addr[N];
  logic [N-1:0]  env_v, env_r;

  initial begin
    for (int i = 0; i < N; i++) begin
      e_busy[i] = 1'b0;
      e_cnt[i]  = 0;
      e_addr[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int i = 0; i < N; i++) e_busy[i] = 1'b0;
        core_req       = '0;
        core_res_valid = '0;
        core_res       = '0;
      end else begin
        if (done) done_cnt++;
        env_v = '0;
        env_r = 16'($urandom);
        for (int i = 0; i < N; i++) begin
          if (core_gnt[i]) begin
            gnt_rec_t rec;
            rec.core = 4'(i);
            rec.addr = core_addr;
            glog.push_back(rec);
            e_busy[i] = 1'b1;
            e_addr[i] = core_addr;
            e_cnt[i]  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5));
          end else if (e_busy[i] && !hold_res) begin
            e_cnt[i]--;
            if (e_cnt[i] <= 0) begin
              env_v[i]  = 1'b1;
              env_r[i]  = (res_mode == 0) ? 1'b0 :
                          (res_mode == 1) ? ~e_addr[i][0] : 1'($urandom);
              e_busy[i] = 1'b0;
            end
          end
        end
        if (stray_en && $urandom_range(0, 3) == 0) begin
          int s;
          s = int'($urandom_range(0, N - 1));
          if (!e_busy[s] && !env_v[s]) begin
            env_v[s] = 1'b1;
            env_r[s] = 1'b1;
          end
        end
        core_res_valid = env_v;
        core_res       = env_r;
        core_req       = req_mask;
      end
    end
  end

  // ---------------- behavioural model ----------------
  int             m_phase = P_IDLE;
  int             m_next = 0;
  int             m_ptr = 0;
  int             m_job[N];
  logic [N-1:0]   m_busy = '0;
  logic [N-1:0]   e_gnt = '0;
  logic [AW-1:0]  e_addr_m = '0;
  logic [AW:0]    m_count = '0;
  bit             e_busy_o = 1'b0;
  bit             e_done = 1'b0;
  logic [DEPTH-1:0] m_map = '0;

  task automatic model_step();
    logic [N-1:0] counted, elig, prev_gnt;
    if (!reset) begin
      m_phase = P_IDLE; m_next = 0; m_ptr = 0; m_busy = '0; e_gnt = '0;
      e_addr_m = '0; m_count = '0; e_busy_o = 1'b0; e_done = 1'b0; m_map = '0;
      return;
    end
    counted  = core_res_valid & core_res & m_busy;
    prev_gnt = e_gnt;
    e_gnt    = '0;
    case (m_phase)
      P_IDLE: if (start) begin
        m_next = 0; m_count = '0; m_ptr = 0; m_map = '0; m_phase = P_DISP;
      end
      P_DISP: begin
        elig = core_req & ~m_busy;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (e_gnt == '0 && elig[c]) begin
            e_gnt[c] = 1'b1;
            e_addr_m = 8'(m_next);
            m_job[c] = m_next;
            m_next++;
            m_ptr = (c + 1) % N;
          end
        end
        if (m_next == DEPTH) m_phase = P_DRAIN;
      end
      P_DRAIN: if (m_busy == '0 && prev_gnt == '0) m_phase = P_DONE;
      default: m_phase = P_IDLE;
    endcase
    m_count = m_count + 9'($countones(counted));
    for (int i = 0; i < N; i++) if (counted[i]) m_map[m_job[i]] = 1'b1;
    m_busy   = (m_busy & ~core_res_valid) | e_gnt;
    e_busy_o = (m_phase == P_DISP) || (m_phase == P_DRAIN);
    e_done   = (m_phase == P_DONE);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_job[i] = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("core_gnt", 256'(core_gnt), 256'(e_gnt));
        if (e_gnt != '0) check("core_addr", 256'(core_addr), 256'(e_addr_m));
        check("busy", 256'(busy), 256'(e_busy_o));
        check("done", 256'(done), 256'(e_done));
        check("prime_count", 256'(prime_count), 256'(m_count));
`ifdef JOB_DISPATCHER_BITMAP_EN
        check("prime_map", prime_map, m_map);
`endif
      end
    end
  end

  // ---------------- sequence helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int t = 0;
    while (glog.size() < n && t < budget) begin @(negedge clk); t++; end
    check(name, 256'(glog.size() >= n), 256'(1));
  endtask

  task automatic wait_done(input int budget, input string name);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin @(negedge clk); t++; end
    check(name, 256'(done_cnt > 0), 256'(1));
  endtask

  task automatic wait_idle(input int core, input int budget);
    int t = 0;
    while (e_busy[core] && t < budget) begin @(negedge clk); t++; end
    check("core idle wait", 256'(e_busy[core]), 256'(0));
  endtask

  task automatic new_run();
    glog.delete();
    done_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int bad;
    #1 reset = 1'b0;
    #2;
    check("rst core_gnt", 256'(core_gnt), 256'(0));
    check("rst core_addr", 256'(core_addr), 256'(0));
    check("rst busy", 256'(busy), 256'(0));
    check("rst done", 256'(done), 256'(0));
    check("rst prime_count", 256'(prime_count), 256'(0));
    tick(3);
    #2 reset = 1'b1;

    // Single core, fixed latency, all results not prime; strays from idle cores.
    new_run();
    req_mask = 16'h0001; res_mode = 0; lat_fixed = 2; stray_en = 1'b1;
    pulse_start();
    wait_done(3000, "A done");
    stray_en = 1'b0;
    tick(5);
    check("A grants", 256'(glog.size()), 256'(DEPTH));
    bad = 0;
    foreach (glog[k]) if (glog[k].core != 4'd0 || int'(glog[k].addr) != k) bad++;
    check("A order", 256'(bad), 256'(0));
    check("A prime_count", 256'(prime_count), 256'(0));
    check("A done pulses", 256'(done_cnt), 256'(1));
    check("A busy after", 256'(busy), 256'(0));

    // All cores request, results held back, then even addresses prime.
    new_run();
    req_mask = '1; res_mode = 1; lat_fixed = 0; hold_res = 1'b1;
    pulse_start();
    wait_log(16, 100, "B first 16");
    tick(10);
    check("B stalled grants", 256'(glog.size()), 256'(16));
    for (int i = 0; i < 16 && i < glog.size(); i++) begin
      check("B grant core", 256'(glog[i].core), 256'(i));
      check("B grant addr", 256'(glog[i].addr), 256'(i));
    end
    hold_res = 1'b0; stray_en = 1'b1;
    tick(20);
    pulse_start();
    wait_done(5000, "B done");
    stray_en = 1'b0;
    tick(5);
    check("B prime_count", 256'(prime_count), 256'(128));
    check("B grants", 256'(glog.size()), 256'(DEPTH));
    check("B done pulses", 256'(done_cnt), 256'(1));
`ifdef JOB_DISPATCHER_BITMAP_EN
    check("B prime_map", prime_map, {128{2'b01}});
`endif

    // Round-robin pointer placement with cores 3 and 5.
    new_run();
    req_mask = 16'h0008; res_mode = 2; lat_fixed = 5;
    pulse_start();
    wait_log(1, 50, "C first grant");
    req_mask = '0;
    wait_idle(3, 50);
    tick(3);
    req_mask = 16'h0028;
    wait_log(3, 50, "C pair grants");
    req_mask = '0;
    wait_idle(3, 50);
    wait_idle(5, 50);
    tick(3);
    req_mask = 16'h0028;
    wait_log(4, 50, "C repeat grant");
    if (glog.size() >= 4) begin
      check("C g0 core", 256'(glog[0].core), 256'(3));
      check("C g1 core", 256'(glog[1].core), 256'(5));
      check("C g1 addr", 256'(glog[1].addr), 256'(1));
      check("C g2 core", 256'(glog[2].core), 256'(3));
      check("C g3 core", 256'(glog[3].core), 256'(5));
      check("C g3 addr", 256'(glog[3].addr), 256'(3));
    end
    req_mask = '1; lat_fixed = 0;
    wait_done(5000, "C done");
    tick(5);

    // Asynchronous reset in the middle of a run, then a clean rerun.
    new_run();
    req_mask = '1; res_mode = 2;
    pulse_start();
    wait_log(100, 1000, "R 100 grants");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("R core_gnt", 256'(core_gnt), 256'(0));
    check("R core_addr", 256'(core_addr), 256'(0));
    check("R busy", 256'(busy), 256'(0));
    check("R done", 256'(done), 256'(0));
    check("R prime_count", 256'(prime_count), 256'(0));
    tick(3);
    #2 reset = 1'b1;
    new_run();
    pulse_start();
    wait_done(5000, "R rerun done");
    tick(5);
    check("R rerun grants", 256'(glog.size()), 256'(DEPTH));
    if (glog.size() > 0) check("R first addr", 256'(glog[0].addr), 256'(0));
    check("R done pulses", 256'(done_cnt), 256'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
